// File: rtl/axi_lite_master_port.sv
// Single-outstanding AXI4-Lite initiator: converts a req/gnt memory-style port into single-beat
// AXI-Lite reads and writes, with a registered one-cycle completion pulse.

package axi_lite_master_port_pkg;

    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned IdWidth   = 10;
    localparam int unsigned UserWidth = 1;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [5:0]           atop;
        logic [UserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
        logic [UserWidth-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [UserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_resp_t;

endpackage

module axi_lite_master_port #(
    parameter int unsigned            AXI_ADDR_WIDTH = 64,
    parameter int unsigned            AXI_DATA_WIDTH = 64,
    parameter int unsigned            AXI_ID_WIDTH   = 10,
    parameter logic [AXI_ID_WIDTH-1:0] AXI_ID        = '0,
    parameter type                    axi_req_t      = axi_lite_master_port_pkg::axi_req_t,
    parameter type                    axi_resp_t     = axi_lite_master_port_pkg::axi_resp_t
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
    output logic                        gnt_o,
    output logic                        rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
    output logic                        err_o,
    output axi_req_t                    axi_req_o,
    input  axi_resp_t                   axi_resp_i
);

    localparam logic [2:0] AxSize    = 3'($clog2(AXI_DATA_WIDTH / 8));
    localparam logic [1:0] BurstIncr = 2'b01;

    typedef enum logic [2:0] {
        StIdle,
        StWrAddrData,
        StWrResp,
        StRdAddr,
        StRdData
    } state_e;

    state_e                      state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [AXI_DATA_WIDTH/8-1:0] be_q, be_d;
    logic                        aw_done_q, aw_done_d;
    logic                        w_done_q, w_done_d;
    logic                        rvalid_q, rvalid_d;
    logic                        err_q, err_d;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;

    // Response ids, last and user are deliberately ignored.
    logic unused_resp;
    assign unused_resp = ^axi_resp_i;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rvalid_d  = 1'b0;
        err_d     = err_q;
        rdata_d   = rdata_q;
        gnt_o     = 1'b0;

        // Payload always comes from the latched request so it stays stable while valid.
        axi_req_o          = '0;
        axi_req_o.aw.id    = AXI_ID;
        axi_req_o.aw.addr  = addr_q;
        axi_req_o.aw.size  = AxSize;
        axi_req_o.aw.burst = BurstIncr;
        axi_req_o.w.data   = wdata_q;
        axi_req_o.w.strb   = be_q;
        axi_req_o.w.last   = 1'b1;
        axi_req_o.ar.id    = AXI_ID;
        axi_req_o.ar.addr  = addr_q;
        axi_req_o.ar.size  = AxSize;
        axi_req_o.ar.burst = BurstIncr;

        unique case (state_q)
            StIdle: begin
                gnt_o = req_i;
                if (req_i) begin
                    addr_d    = addr_i;
                    wdata_d   = wdata_i;
                    be_d      = be_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = we_i ? StWrAddrData : StRdAddr;
                end
            end
            StWrAddrData: begin
                axi_req_o.aw_valid = !aw_done_q;
                axi_req_o.w_valid  = !w_done_q;
                if (axi_req_o.aw_valid && axi_resp_i.aw_ready) aw_done_d = 1'b1;
                if (axi_req_o.w_valid && axi_resp_i.w_ready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = StWrResp;
            end
            StWrResp: begin
                axi_req_o.b_ready = 1'b1;
                if (axi_resp_i.b_valid) begin
                    rvalid_d = 1'b1;
                    err_d    = axi_resp_i.b.resp[1];
                    state_d  = StIdle;
                end
            end
            StRdAddr: begin
                axi_req_o.ar_valid = 1'b1;
                if (axi_resp_i.ar_ready) state_d = StRdData;
            end
            StRdData: begin
                axi_req_o.r_ready = 1'b1;
                if (axi_resp_i.r_valid) begin
                    rvalid_d = 1'b1;
                    err_d    = axi_resp_i.r.resp[1];
                    rdata_d  = axi_resp_i.r.data;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;

`ifndef SYNTHESIS
    aw_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
        axi_req_o.aw_valid && !axi_resp_i.aw_ready |=> axi_req_o.aw_valid && $stable(axi_req_o.aw));
    w_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
        axi_req_o.w_valid && !axi_resp_i.w_ready |=> axi_req_o.w_valid && $stable(axi_req_o.w));
    ar_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
        axi_req_o.ar_valid && !axi_resp_i.ar_ready |=> axi_req_o.ar_valid && $stable(axi_req_o.ar));
    rvalid_pulse_a: assert property (@(posedge clk_i) disable iff (rst_i)
        rvalid_o |=> !rvalid_o);
`endif

endmodule

// File: tb/tb_axi_lite_master_port.sv
// Bench for axi_lite_master_port: a configurable AXI-Lite slave with memory, and a scoreboard
// of expected completions popped whenever rvalid pulses.

module tb_axi_lite_master_port;
    import axi_lite_master_port_pkg::*;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          gcyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we, gnt, rvalid, err;
    logic [63:0] addr, wdata, rdata;
    logic [7:0]  be;
    axi_req_t    axi_req;
    axi_resp_t   axi_resp;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_rv = 0;
    int n_exp_rv = 0;
    int last_gnt_cyc, last_rv_cyc;
    logic [63:0] model_rdata = '0;
    exp_t sb[$];

    // slave configuration and memory
    int          cfg_aw_wait, cfg_w_wait, cfg_ar_wait, cfg_b_wait, cfg_r_wait;
    logic [1:0]  cfg_b_resp, cfg_r_resp;
    logic [63:0] mem [logic [63:0]];

    axi_lite_master_port #(
        .AXI_ADDR_WIDTH(64),
        .AXI_DATA_WIDTH(64),
        .AXI_ID_WIDTH  (10),
        .AXI_ID        (10'd0),
        .axi_req_t     (axi_req_t),
        .axi_resp_t    (axi_resp_t)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .we_i      (we),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .be_i      (be),
        .gnt_o     (gnt),
        .rvalid_o  (rvalid),
        .rdata_o   (rdata),
        .err_o     (err),
        .axi_req_o (axi_req),
        .axi_resp_i(axi_resp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Slave: readies/valids are chosen at the falling edge from the master's state-only valids.
    initial begin : slave
        logic        aw_got, w_got, ar_got, b_hs, r_hs, aw_stall, w_stall, ar_stall;
        int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        logic [63:0] aw_addr, ar_addr, w_data, st_aw_addr, st_ar_addr, st_w_data, tmp;
        logic [7:0]  w_strb, st_w_strb;
        axi_resp = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                axi_resp = '0;
                {aw_got, w_got, ar_got, b_hs, r_hs, aw_stall, w_stall, ar_stall} = '0;
                {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
                continue;
            end
            // B channel
            if (b_hs) begin
                axi_resp.b_valid = 1'b0;
                b_hs = 1'b0;
            end else if (aw_got && w_got) begin
                if (b_cnt >= cfg_b_wait) begin
                    axi_resp.b_valid  = 1'b1;
                    axi_resp.b.resp = cfg_b_resp;
                    if (axi_req.b_ready) begin
                        tmp = mem.exists(aw_addr) ? mem[aw_addr] : 64'h0;
                        for (int i = 0; i < 8; i++) if (w_strb[i]) tmp[8*i +: 8] = w_data[8*i +: 8];
                        mem[aw_addr] = tmp;
                        b_hs = 1'b1;
                        aw_got = 1'b0;
                        w_got = 1'b0;
                        b_cnt = 0;
                    end
                end else b_cnt++;
            end
            // AW channel
            axi_resp.aw_ready = 1'b0;
            if (aw_stall) begin
                check("aw_hold_valid", axi_req.aw_valid, 1);
                check("aw_hold_addr", axi_req.aw.addr, st_aw_addr);
            end
            if (aw_got) check("aw_valid_after_hs", axi_req.aw_valid, 0);
            aw_stall = 1'b0;
            if (axi_req.aw_valid && !aw_got) begin
                if (aw_cnt >= cfg_aw_wait) begin
                    axi_resp.aw_ready = 1'b1;
                    aw_got = 1'b1;
                    aw_cnt = 0;
                    aw_addr = axi_req.aw.addr;
                    check("aw_len", axi_req.aw.len, 0);
                    check("aw_size", axi_req.aw.size, 3);
                    check("aw_burst", axi_req.aw.burst, 1);
                    check("aw_id", axi_req.aw.id, 0);
                end else begin
                    aw_cnt++;
                    aw_stall = 1'b1;
                    st_aw_addr = axi_req.aw.addr;
                end
            end
            // W channel
            axi_resp.w_ready = 1'b0;
            if (w_stall) begin
                check("w_hold_valid", axi_req.w_valid, 1);
                check("w_hold_data", axi_req.w.data, st_w_data);
                check("w_hold_strb", axi_req.w.strb, st_w_strb);
            end
            if (w_got) check("w_valid_after_hs", axi_req.w_valid, 0);
            w_stall = 1'b0;
            if (axi_req.w_valid && !w_got) begin
                if (w_cnt >= cfg_w_wait) begin
                    axi_resp.w_ready = 1'b1;
                    w_got = 1'b1;
                    w_cnt = 0;
                    w_data = axi_req.w.data;
                    w_strb = axi_req.w.strb;
                    check("w_last", axi_req.w.last, 1);
                end else begin
                    w_cnt++;
                    w_stall = 1'b1;
                    st_w_data = axi_req.w.data;
                    st_w_strb = axi_req.w.strb;
                end
            end
            // R channel
            if (r_hs) begin
                axi_resp.r_valid = 1'b0;
                r_hs = 1'b0;
            end else if (ar_got) begin
                if (r_cnt >= cfg_r_wait) begin
                    axi_resp.r_valid = 1'b1;
                    axi_resp.r.data  = mem.exists(ar_addr) ? mem[ar_addr] : 64'h0;
                    axi_resp.r.resp  = cfg_r_resp;
                    if (axi_req.r_ready) begin
                        r_hs = 1'b1;
                        ar_got = 1'b0;
                        r_cnt = 0;
                    end
                end else r_cnt++;
            end
            // AR channel
            axi_resp.ar_ready = 1'b0;
            if (ar_stall) begin
                check("ar_hold_valid", axi_req.ar_valid, 1);
                check("ar_hold_addr", axi_req.ar.addr, st_ar_addr);
            end
            ar_stall = 1'b0;
            if (axi_req.ar_valid && !ar_got) begin
                if (ar_cnt >= cfg_ar_wait) begin
                    axi_resp.ar_ready = 1'b1;
                    ar_got = 1'b1;
                    ar_cnt = 0;
                    ar_addr = axi_req.ar.addr;
                    check("ar_size", axi_req.ar.size, 3);
                    check("ar_len", axi_req.ar.len, 0);
                end else begin
                    ar_cnt++;
                    ar_stall = 1'b1;
                    st_ar_addr = axi_req.ar.addr;
                end
            end
        end
    end

    // Completion monitor
    initial begin : monitor
        logic prev_rv;
        exp_t e;
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) prev_rv = 1'b0;
            else begin
                if (rvalid) begin
                    check("rvalid_pulse", prev_rv, 0);
                    check("rvalid_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("rdata", rdata, e.rdata);
                        check("err", err, e.err);
                        if (e.lat >= 0) check("latency", cyc - e.gcyc, e.lat);
                    end
                    last_rv_cyc = cyc;
                    n_rv++;
                end
                prev_rv = rvalid;
            end
        end
    end

    task automatic issue(input logic t_we, input logic [63:0] t_addr, input logic [63:0] t_wdata,
                         input logic [7:0] t_be, input logic [63:0] t_rdata, input logic t_err,
                         input int t_lat);
        exp_t e;
        logic granted;
        @(negedge clk);
        req = 1'b1;
        we = t_we;
        addr = t_addr;
        wdata = t_wdata;
        be = t_be;
        if (!t_we) model_rdata = t_rdata;
        e.rdata = model_rdata;
        e.err = t_err;
        e.lat = t_lat;
        e.gcyc = -1;
        sb.push_back(e);
        n_exp_rv++;
        granted = 1'b0;
        for (int n = 0; n < 100 && !granted; n++) begin
            #1;
            if (gnt) granted = 1'b1;
            else @(negedge clk);
        end
        check("gnt_seen", granted, 1);
        if (granted) begin
            sb[sb.size()-1].gcyc = cyc;
            last_gnt_cyc = cyc;
            @(posedge clk);
            #1;
        end
        req = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
        check("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int base_rv, cnt;
        logic seen;
        rst = 1'b1;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        {cfg_aw_wait, cfg_w_wait, cfg_ar_wait, cfg_b_wait, cfg_r_wait} = '0;
        cfg_b_resp = 2'b00;
        cfg_r_resp = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        check("rst_aw_valid", axi_req.aw_valid, 0);
        check("rst_w_valid", axi_req.w_valid, 0);
        check("rst_ar_valid", axi_req.ar_valid, 0);
        check("rst_b_ready", axi_req.b_ready, 0);
        check("rst_r_ready", axi_req.r_ready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        rst = 1'b0;

        // zero-wait write
        base_rv = n_rv;
        issue(1'b1, 64'h0200_4000, 64'hDEAD_BEEF_0000_0001, 8'hFF, '0, 1'b0, 3);
        drain();
        check("single_completion", n_rv - base_rv, 1);

        // W accepted one cycle after AW, then read back and a partial-strobe update
        cfg_w_wait = 1;
        issue(1'b1, 64'h0200_4000, 64'h1111_2222_3333_4444, 8'hFF, '0, 1'b0, -1);
        drain();
        cfg_w_wait = 0;
        issue(1'b0, 64'h0200_4000, '0, 8'h00, 64'h1111_2222_3333_4444, 1'b0, 3);
        drain();
        issue(1'b1, 64'h0200_4000, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, '0, 1'b0, -1);
        issue(1'b0, 64'h0200_4000, '0, 8'h00, 64'h1111_2222_CCCC_DDDD, 1'b0, 3);
        drain();

        // W accepted three cycles before AW; EXOKAY then DECERR responses
        cfg_aw_wait = 3;
        cfg_b_resp = 2'b01;
        issue(1'b1, 64'h0200_4008, 64'h55, 8'hFF, '0, 1'b0, 6);
        drain();
        cfg_aw_wait = 0;
        cfg_b_wait = 2;
        cfg_b_resp = 2'b11;
        issue(1'b1, 64'h0200_4010, 64'h66, 8'hFF, '0, 1'b1, 5);
        drain();
        cfg_b_wait = 0;
        cfg_b_resp = 2'b00;

        // read with AR stall and 4-cycle R stall returning SLVERR
        mem[64'h0200_BFF8] = 64'h1234;
        cfg_ar_wait = 2;
        cfg_r_wait = 4;
        cfg_r_resp = 2'b10;
        issue(1'b0, 64'h0200_BFF8, '0, 8'h00, 64'h1234, 1'b1, 9);
        drain();
        {cfg_ar_wait, cfg_r_wait} = '0;
        cfg_r_resp = 2'b00;

        // back-to-back read then write
        issue(1'b0, 64'h0200_4000, '0, 8'h00, 64'h1111_2222_CCCC_DDDD, 1'b0, 3);
        issue(1'b1, 64'h0200_4000, 64'h77, 8'hFF, '0, 1'b0, 3);
        check("b2b_gnt_with_rvalid", last_gnt_cyc, last_rv_cyc);
        check("b2b_outstanding", sb.size(), 1);
        drain();

        // reset while waiting for B
        cfg_b_wait = 20;
        issue(1'b1, 64'h0200_4018, 64'h99, 8'hFF, '0, 1'b0, -1);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            #1;
            seen = axi_req.b_ready;
        end
        check("reach_wr_resp", seen, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_aw_valid", axi_req.aw_valid, 0);
        check("rst_mid_w_valid", axi_req.w_valid, 0);
        check("rst_mid_b_ready", axi_req.b_ready, 0);
        check("rst_mid_ar_valid", axi_req.ar_valid, 0);
        check("rst_mid_r_ready", axi_req.r_ready, 0);
        check("rst_mid_rvalid", rvalid, 0);
        if (sb.size() != 0) begin
            void'(sb.pop_back());
            n_exp_rv--;
        end
        model_rdata = '0;
        cfg_b_wait = 0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        cnt = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            #1;
            if (rvalid) cnt++;
        end
        check("rst_no_rvalid", cnt, 0);
        check("rst_rdata_cleared", rdata, 0);

        // recovery after reset
        issue(1'b0, 64'h0200_4000, '0, 8'h00, 64'h77, 1'b0, 3);
        drain();
        check("completion_count", n_rv, n_exp_rv);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
